// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: default geometry and the
// clear-sequencer state encoding.
package regfile_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultDepth = 4;

    typedef enum logic {
        StIdle  = 1'b0,  // accepting writes, ready high
        StClear = 1'b1   // walking the file, zeroing one register per cycle
    } rf_state_e;

endpackage

// File: rtl/reg_en_n.sv
// Single storage register with load enable, synchronous clear and
// asynchronous active-high reset.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active high, clears q_o
//   en_i   : load d_i at the next rising edge
//   clr_i  : synchronous clear, wins over en_i
//   d_i    : load data
//   q_o    : stored value
module reg_en_n
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/register_file_n.sv
// Multi-ported register file: one write port, two combinational read ports,
// register 0 hardwired to zero, optional write-to-read forwarding and a
// sequenced clear that zeroes registers 1..DEPTH-1 one per cycle.
//   clk_i     : clock, rising edge
//   rst_i     : asynchronous reset, active high
//   we_i      : write enable (ignored while a clear sequence runs)
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_a_i : read port A address
//   rdata_a_o : read port A data
//   raddr_b_i : read port B address
//   rdata_b_o : read port B data
//   clear_i   : start a clear sequence (ignored while one is running)
//   ready_o   : high when idle and accepting writes
module register_file_n
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic             clear_i,
    output logic             ready_o
);

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             wr_ok;
    logic [WIDTH-1:0] rf_rd [DEPTH];

    // A write is only effective in idle and never to the hardwired zero entry.
    assign wr_ok   = we_i && (state_q == StIdle) && (waddr_i != '0);
    assign ready_o = (state_q == StIdle);

    // Clear sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (clear_i) begin
                    state_d = StClear;
                    idx_d   = AW'(1);
                end
            end
            StClear: begin
                // Index saturates at the last entry rather than wrapping.
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage: entry 0 has no flops.
    assign rf_rd[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        logic en;
        logic clr;

        assign en  = wr_ok && (waddr_i == AW'(i));
        assign clr = (state_q == StClear) && (idx_q == AW'(i));

        reg_en_n #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (en),
            .clr_i (clr),
            .d_i   (wdata_i),
            .q_o   (rf_rd[i])
        );
    end

    // Read ports with optional forwarding. Forwarding is suppressed during
    // reset so both ports read zero while rst_i is high.
    always_comb begin
        rdata_a_o = rf_rd[raddr_a_i];
        rdata_b_o = rf_rd[raddr_b_i];
        if (BYPASS && wr_ok && !rst_i) begin
            if (waddr_i == raddr_a_i) begin
                rdata_a_o = wdata_i;
            end
            if (waddr_i == raddr_b_i) begin
                rdata_b_o = wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_register_file_n.sv
// Self-checking bench for register_file_n: a forwarding and a non-forwarding
// 4-entry instance share stimulus; an 8-entry instance covers clear/reset.
module tb_register_file_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 4-entry instances
    logic       rst, we, clr;
    logic [1:0] wa, ra, rb;
    logic [7:0] wd;
    logic [7:0] a_byp, b_byp, a_nb, b_nb;
    logic       rdy_byp, rdy_nb;

    // 8-entry instance
    logic       rst8, we8, clr8;
    logic [2:0] wa8, ra8, rb8;
    logic [7:0] wd8, a8, b8;
    logic       rdy8;

    register_file_n #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(wa), .wdata_i(wd),
        .raddr_a_i(ra), .rdata_a_o(a_byp), .raddr_b_i(rb), .rdata_b_o(b_byp),
        .clear_i(clr), .ready_o(rdy_byp)
    );

    register_file_n #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(wa), .wdata_i(wd),
        .raddr_a_i(ra), .rdata_a_o(a_nb), .raddr_b_i(rb), .rdata_b_o(b_nb),
        .clear_i(clr), .ready_o(rdy_nb)
    );

    register_file_n #(.WIDTH(8), .DEPTH(8), .BYPASS(1'b1)) dut8 (
        .clk_i(clk), .rst_i(rst8), .we_i(we8), .waddr_i(wa8), .wdata_i(wd8),
        .raddr_a_i(ra8), .rdata_a_o(a8), .raddr_b_i(rb8), .rdata_b_o(b8),
        .clear_i(clr8), .ready_o(rdy8)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;
    sb_t sbq[$];

    task automatic push(input string n, input logic [7:0] e);
        sbq.push_back('{n, e});
    endtask

    task automatic pop_check(input logic [7:0] act);
        sb_t s;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h expected nothing", act);
        end else begin
            s = sbq.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
            end
        end
    endtask

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] ea_nb;
        logic [7:0] eb_nb;
    } vec_t;
    vec_t vecs[10];

    initial begin
        //              we  wa    wd     ra    rb    ea     eb     ea_nb  eb_nb
        vecs[0] = '{1'b1, 2'd1, 8'hA5, 2'd1, 2'd0, 8'hA5, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 2'd2, 8'h3C, 2'd1, 2'd2, 8'hA5, 8'h3C, 8'hA5, 8'h00};
        vecs[2] = '{1'b1, 2'd3, 8'hFF, 2'd2, 2'd3, 8'h3C, 8'hFF, 8'h3C, 8'h00};
        vecs[3] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 8'hA5, 8'hFF, 8'hA5, 8'hFF};
        vecs[4] = '{1'b1, 2'd0, 8'h77, 2'd0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'hA5, 8'h00, 8'hA5};
        vecs[6] = '{1'b1, 2'd2, 8'h5A, 2'd2, 2'd2, 8'h5A, 8'h5A, 8'h3C, 8'h3C};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        vecs[8] = '{1'b1, 2'd3, 8'h12, 2'd3, 2'd1, 8'h12, 8'hA5, 8'hFF, 8'hA5};
        vecs[9] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 8'h12, 8'h00, 8'h12, 8'h00};

        rst = 1'b1; we = 1'b0; clr = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
        rst8 = 1'b1; we8 = 1'b0; clr8 = 1'b0; wa8 = '0; wd8 = '0; ra8 = '0; rb8 = '0;

        // During reset: reads zero, ready high, a write (incl. forwarding) ignored
        #2;
        we = 1'b1; wa = 2'd1; wd = 8'hFF; ra = 2'd1; rb = 2'd1;
        #1;
        push("rst_a_byp", 8'h00); push("rst_b_byp", 8'h00); push("rst_a_nb", 8'h00);
        push("rst_rdy_byp", 8'h01); push("rst_rdy_nb", 8'h01);
        pop_check(a_byp); pop_check(b_byp); pop_check(a_nb);
        pop_check({7'd0, rdy_byp}); pop_check({7'd0, rdy_nb});

        @(negedge clk);
        we = 1'b0; rst = 1'b0; rst8 = 1'b0;
        #2;
        push("post_rst_r1", 8'h00);
        pop_check(a_byp);

        // Table-driven write/read/forwarding vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra = vecs[i].ra; rb = vecs[i].rb;
            #2;
            push($sformatf("v%0d_a_byp", i), vecs[i].ea);
            push($sformatf("v%0d_b_byp", i), vecs[i].eb);
            push($sformatf("v%0d_a_nb", i), vecs[i].ea_nb);
            push($sformatf("v%0d_b_nb", i), vecs[i].eb_nb);
            push($sformatf("v%0d_rdy", i), 8'h01);
            pop_check(a_byp); pop_check(b_byp); pop_check(a_nb); pop_check(b_nb);
            pop_check({7'd0, rdy_byp});
        end

        // clear together with a write to r2 in idle: write lands, then is cleared
        @(negedge clk);
        we = 1'b1; wa = 2'd2; wd = 8'h99; clr = 1'b1; ra = 2'd2; rb = 2'd0;
        @(negedge clk);
        we = 1'b0; clr = 1'b0;
        #2;
        push("cw_r2_written", 8'h99); push("cw_ready_low", 8'h00);
        pop_check(a_byp); pop_check({7'd0, rdy_byp});
        @(negedge clk);
        rb = 2'd1;
        #2;
        push("cw_r1_cleared", 8'h00); push("cw_nb_ready_low", 8'h00);
        pop_check(b_nb); pop_check({7'd0, rdy_nb});
        @(negedge clk);
        #2;
        push("cw_r2_cleared", 8'h00); push("cw_ready_low_idx3", 8'h00);
        pop_check(a_byp); pop_check({7'd0, rdy_byp});
        @(negedge clk);
        ra = 2'd3;
        #2;
        push("cw_ready_back", 8'h01); push("cw_r3_cleared", 8'h00);
        pop_check({7'd0, rdy_byp}); pop_check(a_nb);

        // 8-entry: fill r1..r7 with 0x11
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            we8 = 1'b1; wa8 = 3'(i); wd8 = 8'h11;
        end
        @(negedge clk);
        we8 = 1'b0; clr8 = 1'b1;
        // Cycle k of the sequence: rk still 0x11, r(k-1) already 0.
        // clear re-asserted at k=2 must not restart; write to r5 at k=3 dropped.
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            clr8 = (k == 2);
            we8 = (k == 3); wa8 = 3'd5; wd8 = 8'hEE;
            ra8 = 3'(k);
            rb8 = (k == 3 || k == 4) ? 3'd5 : 3'(k - 1);
            #2;
            push($sformatf("c8_k%0d_ready", k), 8'h00);
            push($sformatf("c8_k%0d_a", k), 8'h11);
            push($sformatf("c8_k%0d_b", k), (k == 3 || k == 4) ? 8'h11 : 8'h00);
            pop_check({7'd0, rdy8}); pop_check(a8); pop_check(b8);
        end
        @(negedge clk);
        we8 = 1'b0; clr8 = 1'b0;
        #2;
        push("c8_ready_after_7", 8'h01);
        pop_check({7'd0, rdy8});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ra8 = 3'(i);
            #2;
            push($sformatf("c8_r%0d_zero", i), 8'h00);
            pop_check(a8);
        end

        // Reset in the middle of a clear sequence
        @(negedge clk);
        we8 = 1'b1; wa8 = 3'd3; wd8 = 8'h33;
        @(negedge clk);
        wa8 = 3'd6; wd8 = 8'h66;
        @(negedge clk);
        we8 = 1'b0; clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        @(negedge clk);
        ra8 = 3'd3; rb8 = 3'd6;
        #2;
        push("mr_pre_r3", 8'h33); push("mr_pre_r6", 8'h66); push("mr_pre_ready", 8'h00);
        pop_check(a8); pop_check(b8); pop_check({7'd0, rdy8});
        #1 rst8 = 1'b1;
        #1;
        push("mr_rst_r3", 8'h00); push("mr_rst_r6", 8'h00); push("mr_rst_ready", 8'h01);
        pop_check(a8); pop_check(b8); pop_check({7'd0, rdy8});
        @(negedge clk);
        rst8 = 1'b0;
        @(negedge clk);
        #2;
        push("mr_no_residual", 8'h01);
        pop_check({7'd0, rdy8});
        @(negedge clk);
        we8 = 1'b1; wa8 = 3'd3; wd8 = 8'h42;
        @(negedge clk);
        we8 = 1'b0; ra8 = 3'd3; rb8 = 3'd6;
        #2;
        push("mr_r3_42", 8'h42); push("mr_r6_zero", 8'h00); push("mr_ready", 8'h01);
        pop_check(a8); pop_check(b8); pop_check({7'd0, rdy8});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
